// File: rtl/pipe_adder.sv
// Pipelined N-bit signed adder/subtractor: carry chain cut into STAGES slices, valid/ready flow control.
// Optional signed-overflow output is enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         co
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned W    = N / STAGES;
    localparam int unsigned SW   = W + 1;
    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [N-1:0]      a_q [STAGES];
    logic [N-1:0]      a_d [STAGES];
    logic [N-1:0]      b_q [STAGES];
    logic [N-1:0]      b_d [STAGES];
    logic [N-1:0]      s_q [STAGES];
    logic [N-1:0]      s_d [STAGES];

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [N-1:0]      a_in [STAGES];
    logic [N-1:0]      b_in [STAGES];
    logic [N-1:0]      s_in [STAGES];
    logic [W:0]        slice_sum [STAGES];

    // Stage inputs, backward ready chain and per-stage slice add
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end

        v_in[0] = in_valid;
        c_in[0] = ci;
        a_in[0] = A;
        b_in[0] = sub ? ~B : B;
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = v_q[k-1];
            c_in[k] = c_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = v_q[k];
            c_d[k] = c_q[k];
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
            slice_sum[k] = {1'b0, a_in[k][k*W +: W]} + {1'b0, b_in[k][k*W +: W]} + SW'(c_in[k]);
            if (rdy[k]) begin
                v_d[k] = v_in[k];
                // Data only moves with a real beat, so empty slots leave registers untouched
                if (v_in[k]) begin
                    a_d[k]          = a_in[k];
                    b_d[k]          = b_in[k];
                    s_d[k]          = s_in[k];
                    s_d[k][k*W +: W] = slice_sum[k][W-1:0];
                    c_d[k]          = slice_sum[k][W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow from the operand sign bits that reach the last stage with the top slice
    always_comb begin
        ovf_d = ovf_q;
        if (rdy[LAST] && v_in[LAST]) begin
            ovf_d = (a_in[LAST][N-1] == b_in[LAST][N-1]) &&
                    (slice_sum[LAST][W-1] != a_in[LAST][N-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = rdy[0];
    assign out_valid = v_q[LAST];
    assign S         = s_q[LAST];
    assign co        = c_q[LAST];

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (N=8, STAGES=2): directed vectors, random stream with
// back-pressure, fill/drain, and mid-flight reset, against a whole-word arithmetic model.
module tb_pipe_adder;

    localparam int unsigned N      = 8;
    localparam int unsigned STAGES = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         ci = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] S;
    logic         co;
    logic         ovf;

`ifdef PIPE_ADDER_OVF_EN
    localparam bit HAS_OVF = 1'b1;
`else
    localparam bit HAS_OVF = 1'b0;
    assign ovf = 1'b0;
`endif

    pipe_adder #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .co        (co)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_in     = 0;
    int n_out    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: plain (N+1)-bit arithmetic on the whole word, packed as {S, co, ovf}
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic c, input logic s);
        logic [N-1:0] be;
        logic [N:0]   sum;
        logic         ov;
        be  = s ? ~b : b;
        sum = {1'b0, a} + {1'b0, be} + (N+1)'(c);
        ov  = (a[N-1] == be[N-1]) && (sum[N-1] != a[N-1]);
        return {sum[N-1:0], sum[N], ov & HAS_OVF};
    endfunction

    logic [N+1:0] exp_q [$];
    logic         prev_stall = 1'b0;
    logic [N+1:0] prev_res   = '0;
    wire  [N+1:0] dut_res    = {S, co, ovf};

    // Scoreboard: handshakes are decided by the values settled at the falling edge
    always @(negedge clk) begin
        logic [N+1:0] e;
        if (!rst) begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'(dut_res), 32'(prev_res));
            end
            if (out_valid && out_ready) begin
                check("spurious_out", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("result", 32'(dut_res), 32'(e));
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(A, B, ci, sub));
                n_in++;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = dut_res;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_beat();
        A   = N'($urandom);
        B   = N'($urandom);
        ci  = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic drain(input string tag);
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard     = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // One beat into an empty pipe; checks latency and the expected constants
    task automatic directed(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic c, input logic s, input logic [N-1:0] es,
                            input logic eco, input logic eovf);
        A = a; B = b; ci = c; sub = s;
        out_ready = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < int'(STAGES); i++) begin
            check({tag, "_early"}, 32'(out_valid), 32'd0);
            tick();
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_S"}, 32'(S), 32'(es));
        check({tag, "_co"}, 32'(co), 32'(eco));
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf & HAS_OVF));
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int sent, guard, acc;
        logic ok;

        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_S", 32'(S), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        #20 rst = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        directed("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        directed("sub_borrow", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        directed("carry_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        directed("carry_slice", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        drain("directed_drain");

        // Random back-to-back stream with random back-pressure
        sent  = 0;
        guard = 0;
        new_beat();
        in_valid = 1'b1;
        while (sent < 1000 && guard < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ok = in_ready;
            tick();
            guard++;
            if (ok) begin
                sent++;
                new_beat();
            end
        end
        check("stream_sent", 32'(sent), 32'd1000);
        drain("stream_drain");
        check("stream_no_loss", 32'(n_out), 32'(n_in));

        // Full throughput with out_ready held high
        acc = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            new_beat();
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        check("throughput", 32'(acc), 32'd20);
        drain("throughput_drain");

        // Fill under back-pressure, then drain one per cycle
        acc = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        new_beat();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!in_ready) break;
            acc++;
            tick();
            new_beat();
        end
        check("fill_count", 32'(acc), 32'(STAGES));
        check("fill_in_ready", 32'(in_ready), 32'd0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < int'(STAGES); i++) begin
            @(negedge clk);
            check("fill_drain_valid", 32'(out_valid), 32'd1);
            tick();
        end
        @(negedge clk);
        check("fill_drain_empty", 32'(out_valid), 32'd0);
        check("fill_drain_queue", 32'(exp_q.size()), 32'd0);

        // Reset with two beats in flight
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = 8'h11; B = 8'h22; ci = 1'b0; sub = 1'b0;
        tick();
        A = 8'h33; B = 8'h44;
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_S", 32'(S), 32'd0);
        check("midrst_co", 32'(co), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        exp_q.delete();
        tick();
        tick();
        #3 rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_empty", 32'(out_valid), 32'd0);
        directed("post_rst", 8'h40, 8'h40, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);
        drain("final_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Pipelined, parametrised N-bit signed adder/subtractor with a valid/ready handshake. The carry chain is split into STAGES equal slices, with one register slice per stage, so a wide add closes timing at high clock rates. It sustains one operation per clock when not back-pressured. It replaces the flat combinational ripple adder wherever an add sits on a critical path, e.g. accumulators and address generators.

## Interface
- N, default 32: operand and result width in bits; must be a multiple of STAGES.
- STAGES, default 4: number of pipeline stages; 1 ≤ STAGES ≤ N. Slice width is W = N/STAGES.
- clk  in  1: clock; all state updates on its rising edge.
- rst  in  1: reset; asynchronous, active-high.
- in_valid  in  1: operand beat present.
- in_ready  out  1: block accepts a beat this cycle.
- A  in  N: operand, signed.
- B  in  N: operand, signed.
- ci  in  1: carry-in.
- sub  in  1: 0 computes A+B+ci; 1 computes A+~B+ci. Drive ci=1 for a true A−B.
- out_valid  out  1: result beat present.
- out_ready  in  1: downstream accepts the result.
- S  out  N: sum, signed.
- co  out  1: carry-out of bit N−1. In subtract mode co=1 means no borrow.
- ovf  out  1: signed overflow. Exists only when PIPE_ADDER_OVF_EN is defined.

## Operation
- A beat is accepted when in_valid && in_ready.
- Effective operand: Beff = sub ? ~B : B. Both sub and ci are sampled with the beat.
- Stage k (0..STAGES−1) adds slice [kW+W−1:kW] of A and Beff plus the carry registered by stage k−1. Stage 0 uses ci.
- Input skew: upper slices of A and Beff travel down the pipe until their stage consumes them.
- Output deskew: lower sum slices travel down the pipe alongside the beat.
- Each stage registers its sum slice, its carry-out, and a valid bit.
- Per-stage ready: rdy[k] = !v[k] || rdy[k+1], with rdy[STAGES] = out_ready.
- in_ready = rdy[0]. This is combinational from out_ready through the valid chain.
- A stage loads from its predecessor when rdy[k]. Its valid becomes the predecessor's valid.
- While a result is stalled (out_valid && !out_ready), S, co and ovf hold stable.
- Results leave in acceptance order. No beat is dropped or duplicated.
- Arithmetic is modulo 2^N, with co = bit N of the (N+1)-bit unsigned sum A + Beff + ci.
- ovf = (A[N−1] == Beff[N−1]) && (S[N−1] != A[N−1]). It is computed in the last stage from the delayed sign bits.
- STAGES=1: a single registered adder, latency 1.

## Timing
- Latency: a beat accepted at edge t is presented with out_valid=1 after edge t+STAGES−1, i.e. STAGES cycles after it was presented with in_valid. This holds when the pipe is not stalled.
- Throughput: one beat per cycle under continuous in_valid and out_ready.
- A full pipe (all v=1) with out_ready=0 gives in_ready=0.
- Full pipe, out_ready=1, in_valid=1 in the same cycle: a result leaves and a new beat enters on the same edge. There are no bubbles.
- Bubbles collapse: a stage holding v=0 accepts from upstream even while downstream stalls.
- Reset, asynchronous at any time including mid-operation:
  - all v←0, S←0, co←0, ovf←0, and out_valid=0 immediately;
  - in-flight beats are discarded;
  - in_ready=1 from the first cycle after release.
- Data registers of empty stages are don't-care, but outputs are only sampled when out_valid=1.

## Configuration
- PIPE_ADDER_OVF_EN defined: the ovf port and its sign-bit pipeline registers exist, and the behaviour is as above.
- PIPE_ADDER_OVF_EN undefined: no ovf port and no sign-bit registers. All other behaviour, including latency, is identical.

## Test plan
- N=8, STAGES=2, OVF_EN defined. Add A=0x7F, B=0x01, ci=0, sub=0 → S=0x80, co=0, ovf=1, with out_valid exactly 2 cycles after in_valid.
- Subtract with A=0x05, B=0x07, ci=1, sub=1 → S=0xFE, co=0 (borrow), ovf=0.
- Carry across the slice boundary: A=0xFF, B=0x01, ci=0 → S=0x00, co=1, ovf=0. Then A=0x0F, B=0x01 → S=0x10.
- Back-to-back random stream of 1000 beats with out_ready toggled pseudo-randomly. Every result matches a reference model of A+Beff+ci, in order, with no loss. S, co and ovf stay stable while stalled. Full throughput is reached when out_ready is held at 1.
- Hold out_ready=0 until in_ready falls: exactly STAGES beats are accepted. Release → they drain in order, one per cycle.
- Assert rst with 2 beats in flight → out_valid=0 and S=0 immediately. After release, the first new beat's result is correct and no stale beat appears.
